// File: rtl/vga_timing_pkg.sv
// Shared constants for the programmable VGA timing generator:
// config register map, ctrl bit positions and the 640x480@60 mode.
package vga_timing_pkg;

   localparam int CNT_W = 12;

   localparam logic [3:0] A_H_ACTIVE = 4'd0;
   localparam logic [3:0] A_H_FP     = 4'd1;
   localparam logic [3:0] A_H_SYNC   = 4'd2;
   localparam logic [3:0] A_H_BP     = 4'd3;
   localparam logic [3:0] A_V_ACTIVE = 4'd4;
   localparam logic [3:0] A_V_FP     = 4'd5;
   localparam logic [3:0] A_V_SYNC   = 4'd6;
   localparam logic [3:0] A_V_BP     = 4'd7;
   localparam logic [3:0] A_DIV      = 4'd8;
   localparam logic [3:0] A_CTRL     = 4'd9;

   localparam int C_EN   = 0;
   localparam int C_HPOL = 1;
   localparam int C_VPOL = 2;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_DIV      = 0;

   localparam logic [2:0] DEF_CTRL = 3'b001;

endpackage

// File: rtl/vga_tick_divider.sv
// Programmable clock-enable: one tick every i_div+1 cycles.
// Count is held at zero while disabled or when a new divide is loaded.
module vga_tick_divider #(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_en,
   input  logic         i_clr,
   input  logic [W-1:0] i_div,
   output logic         o_tick
);

   logic [W-1:0] r_cnt;

   assign o_tick = i_en && (r_cnt == i_div);

   // count 0..i_div, restart on tick, clear or disable
   always_ff @(posedge clk) begin
      if (reset || !i_en || i_clr || o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + W'(1);
      end
   end

endmodule

// File: rtl/vga_timing_programmable.sv
// Runtime-programmable VGA timing generator. Mode fields land in
// staging regs and are committed atomically at the frame wrap.
module vga_timing_programmable #(
   parameter int CNT_W        = vga_timing_pkg::CNT_W,
   parameter int DEF_H_ACTIVE = vga_timing_pkg::DEF_H_ACTIVE,
   parameter int DEF_H_FP     = vga_timing_pkg::DEF_H_FP,
   parameter int DEF_H_SYNC   = vga_timing_pkg::DEF_H_SYNC,
   parameter int DEF_H_BP     = vga_timing_pkg::DEF_H_BP,
   parameter int DEF_V_ACTIVE = vga_timing_pkg::DEF_V_ACTIVE,
   parameter int DEF_V_FP     = vga_timing_pkg::DEF_V_FP,
   parameter int DEF_V_SYNC   = vga_timing_pkg::DEF_V_SYNC,
   parameter int DEF_V_BP     = vga_timing_pkg::DEF_V_BP,
   parameter int DEF_DIV      = vga_timing_pkg::DEF_DIV,
   parameter logic [2:0] DEF_CTRL = vga_timing_pkg::DEF_CTRL
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [3:0]       cfg_addr,
   input  logic [CNT_W-1:0] cfg_data,
   output logic             pixel_tick,
   output logic             h_sync,
   output logic             v_sync,
   output logic             de,
   output logic [CNT_W-1:0] h_pixel,
   output logic [CNT_W-1:0] v_pixel,
   output logic             line_start,
   output logic             frame_start,
   output logic             cfg_err
);

   import vga_timing_pkg::*;

   localparam int TW = CNT_W + 2;

   logic [CNT_W-1:0] w_def [0:8];
   logic [CNT_W-1:0] r_s   [0:8];
   logic [CNT_W-1:0] r_a   [0:8];
   logic [CNT_W-1:0] w_n   [0:8];
   logic [CNT_W-1:0] w_x   [0:8];
   logic [2:0]       r_s_ctrl, r_a_ctrl;
   logic [2:0]       w_n_ctrl, w_x_ctrl;
   logic [TW-1:0]    w_n_htot, w_n_vtot;
   logic [TW-1:0]    w_a_htot, w_a_vtot;
   logic [TW-1:0]    r_h, r_v, w_nh, w_nv;
   logic [TW-1:0]    w_hs0, w_hs1, w_vs0, w_vs1;
   logic             r_run, r_err;
   logic             w_tick, w_hlast, w_vlast, w_wrap;
   logic             w_commit, w_valid, w_ok, w_clr;
   logic             w_ls, w_fs, w_de, w_hp, w_vp, w_idle;

   function automatic logic [TW-1:0] tot(
      input logic [CNT_W-1:0] a, b, c, d
   );
      return TW'(a) + TW'(b) + TW'(c) + TW'(d);
   endfunction

   assign w_def[0] = CNT_W'(DEF_H_ACTIVE);
   assign w_def[1] = CNT_W'(DEF_H_FP);
   assign w_def[2] = CNT_W'(DEF_H_SYNC);
   assign w_def[3] = CNT_W'(DEF_H_BP);
   assign w_def[4] = CNT_W'(DEF_V_ACTIVE);
   assign w_def[5] = CNT_W'(DEF_V_FP);
   assign w_def[6] = CNT_W'(DEF_V_SYNC);
   assign w_def[7] = CNT_W'(DEF_V_BP);
   assign w_def[8] = CNT_W'(DEF_DIV);

   // staging view with this cycle's write folded in
   always_comb begin
      for (int i = 0; i < 9; i++) begin
         w_n[i] = (cfg_we && cfg_addr == 4'(i)) ? cfg_data : r_s[i];
      end
      w_n_ctrl = (cfg_we && cfg_addr == A_CTRL) ? cfg_data[2:0] : r_s_ctrl;
   end

   assign w_n_htot = tot(w_n[0], w_n[1], w_n[2], w_n[3]);
   assign w_n_vtot = tot(w_n[4], w_n[5], w_n[6], w_n[7]);
   assign w_a_htot = tot(r_a[0], r_a[1], r_a[2], r_a[3]);
   assign w_a_vtot = tot(r_a[4], r_a[5], r_a[6], r_a[7]);

   assign w_valid = (w_n[A_H_ACTIVE] != '0) && (w_n[A_H_SYNC] != '0)
                 && (w_n[A_V_ACTIVE] != '0) && (w_n[A_V_SYNC] != '0)
                 && !w_n_htot[TW-1] && !w_n_vtot[TW-1];

   assign w_hlast  = (r_h == w_a_htot - TW'(1));
   assign w_vlast  = (r_v == w_a_vtot - TW'(1));
   assign w_wrap   = w_tick && r_run && w_hlast && w_vlast;
   assign w_commit = !r_a_ctrl[C_EN] || w_wrap;
   assign w_ok     = w_commit && w_valid;
   assign w_clr    = w_ok && (w_n[A_DIV] != r_a[A_DIV]);

   // mode in force after this edge; drives output decode
   always_comb begin
      for (int i = 0; i < 9; i++) begin
         w_x[i] = w_ok ? w_n[i] : r_a[i];
      end
      w_x_ctrl = w_ok ? w_n_ctrl : r_a_ctrl;
   end

   vga_tick_divider #(.W(CNT_W)) u_div (
      .clk    (clk),
      .reset  (reset),
      .i_en   (r_a_ctrl[C_EN]),
      .i_clr  (w_clr),
      .i_div  (r_a[A_DIV]),
      .o_tick (w_tick)
   );

   // next raster position; first tick after enable lands on 0,0
   always_comb begin
      w_nh = r_h;
      w_nv = r_v;
      w_ls = 1'b0;
      w_fs = 1'b0;
      if (!r_run) begin
         w_nh = '0;
         w_nv = '0;
         w_ls = 1'b1;
         w_fs = 1'b1;
      end else if (w_hlast) begin
         w_nh = '0;
         w_ls = 1'b1;
         if (w_vlast) begin
            w_nv = '0;
            w_fs = 1'b1;
         end else begin
            w_nv = r_v + TW'(1);
         end
      end else begin
         w_nh = r_h + TW'(1);
      end
   end

   assign w_hs0  = TW'(w_x[0]) + TW'(w_x[1]);
   assign w_hs1  = w_hs0 + TW'(w_x[2]);
   assign w_vs0  = TW'(w_x[4]) + TW'(w_x[5]);
   assign w_vs1  = w_vs0 + TW'(w_x[6]);
   assign w_de   = (w_nh < TW'(w_x[0])) && (w_nv < TW'(w_x[4]));
   assign w_hp   = (w_nh >= w_hs0) && (w_nh < w_hs1);
   assign w_vp   = (w_nv >= w_vs0) && (w_nv < w_vs1);
   assign w_idle = !w_x_ctrl[C_EN] || (!w_tick && !r_run);

   // staging capture, atomic commit and sticky reject flag
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 9; i++) begin
            r_s[i] <= w_def[i];
            r_a[i] <= w_def[i];
         end
         r_s_ctrl <= DEF_CTRL;
         r_a_ctrl <= DEF_CTRL;
         r_err    <= 1'b0;
      end else begin
         for (int i = 0; i < 9; i++) begin
            r_s[i] <= w_n[i];
            r_a[i] <= w_x[i];
         end
         r_s_ctrl <= w_n_ctrl;
         r_a_ctrl <= w_x_ctrl;
         if (w_commit) begin
            r_err <= !w_valid;
         end
      end
   end

   // raster counters, parked at 0,0 while disabled
   always_ff @(posedge clk) begin
      if (reset || !r_a_ctrl[C_EN]) begin
         r_h   <= '0;
         r_v   <= '0;
         r_run <= 1'b0;
      end else if (w_tick) begin
         r_h   <= w_nh;
         r_v   <= w_nv;
         r_run <= 1'b1;
      end
   end

   // registered video outputs and strobes
   always_ff @(posedge clk) begin
      if (reset) begin
         pixel_tick  <= 1'b0;
         de          <= 1'b0;
         h_pixel     <= '0;
         v_pixel     <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         h_sync      <= ~DEF_CTRL[C_HPOL];
         v_sync      <= ~DEF_CTRL[C_VPOL];
      end else if (w_idle) begin
         pixel_tick  <= 1'b0;
         de          <= 1'b0;
         h_pixel     <= '0;
         v_pixel     <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         h_sync      <= ~w_x_ctrl[C_HPOL];
         v_sync      <= ~w_x_ctrl[C_VPOL];
      end else if (w_tick) begin
         pixel_tick  <= 1'b1;
         de          <= w_de;
         h_pixel     <= w_de ? w_nh[CNT_W-1:0] : '0;
         v_pixel     <= w_de ? w_nv[CNT_W-1:0] : '0;
         line_start  <= w_ls;
         frame_start <= w_fs;
         h_sync      <= w_hp ^ ~w_x_ctrl[C_HPOL];
         v_sync      <= w_vp ^ ~w_x_ctrl[C_VPOL];
      end else begin
         pixel_tick  <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

   assign cfg_err = r_err;

endmodule

// File: tb/tb_vga_timing_programmable.sv
// Self-checking bench: random/directed config traffic against a
// tick-index reference model of the raster.
module tb_vga_timing_programmable;

   localparam int W = 12;

   typedef int mode_t [0:9];

   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_we;
   logic [3:0]    cfg_addr;
   logic [W-1:0]  cfg_data;
   logic          pixel_tick, h_sync, v_sync, de;
   logic [W-1:0]  h_pixel, v_pixel;
   logic          line_start, frame_start, cfg_err;

   always #5 clk = ~clk;

   vga_timing_programmable #(
      .DEF_V_ACTIVE (5),
      .DEF_V_FP     (1),
      .DEF_V_SYNC   (2),
      .DEF_V_BP     (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .pixel_tick  (pixel_tick),
      .h_sync      (h_sync),
      .v_sync      (v_sync),
      .de          (de),
      .h_pixel     (h_pixel),
      .v_pixel     (v_pixel),
      .line_start  (line_start),
      .frame_start (frame_start),
      .cfg_err     (cfg_err)
   );

   int n_chk  = 0;
   int n_fail = 0;

   mode_t def_m = '{640, 16, 96, 48, 5, 1, 2, 2, 0, 1};
   mode_t act, st;
   int    gap, p;
   bit    err;
   bit    e_tick, e_hs, e_vs, e_de, e_ls, e_fs;
   int    e_hp, e_vp;

   function automatic int htot(mode_t m);
      return m[0] + m[1] + m[2] + m[3];
   endfunction

   function automatic int vtot(mode_t m);
      return m[4] + m[5] + m[6] + m[7];
   endfunction

   function automatic bit ok_m(mode_t m);
      return m[0] != 0 && m[2] != 0 && m[4] != 0 && m[6] != 0
          && htot(m) < 8192 && vtot(m) < 8192;
   endfunction

   task automatic commit();
      if (ok_m(st)) begin
         act = st;
         err = 1'b0;
      end else begin
         err = 1'b1;
      end
   endtask

   task automatic set_idle();
      e_tick = 0; e_de = 0; e_hp = 0; e_vp = 0;
      e_ls = 0;   e_fs = 0;
      e_hs = ~act[9][1];
      e_vs = ~act[9][2];
   endtask

   task automatic model_step();
      bit tick;
      int fr, h, v;
      if (reset) begin
         st  = def_m;
         act = def_m;
         err = 1'b0;
         gap = act[8] + 1;
         p   = -1;
         set_idle();
         return;
      end
      if (cfg_we && cfg_addr < 10) begin
         st[cfg_addr] = (cfg_addr == 9) ? int'(cfg_data & 7) : int'(cfg_data);
      end
      tick = 0;
      if (!act[9][0]) begin
         commit();
         gap = act[8] + 1;
         p   = -1;
      end else begin
         gap--;
         if (gap == 0) begin
            tick = 1;
            fr = htot(act) * vtot(act);
            if (p < 0) p = 0;
            else if (p == fr - 1) begin
               p = 0;
               commit();
            end else p++;
            gap = act[8] + 1;
         end
      end
      if (!act[9][0] || (!tick && p < 0)) begin
         set_idle();
      end else if (tick) begin
         h = p % htot(act);
         v = p / htot(act);
         e_tick = 1;
         e_de = (h < act[0]) && (v < act[4]);
         e_hp = e_de ? h : 0;
         e_vp = e_de ? v : 0;
         e_ls = (h == 0);
         e_fs = (p == 0);
         e_hs = ((h >= act[0] + act[1]) && (h < act[0] + act[1] + act[2]))
              ^ ~act[9][1];
         e_vs = ((v >= act[4] + act[5]) && (v < act[4] + act[5] + act[6]))
              ^ ~act[9][2];
      end else begin
         e_tick = 0;
         e_ls   = 0;
         e_fs   = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [W-1:0] o,
                      input logic [W-1:0] e);
      n_chk++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h @%0t", tag, o, e, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("tick/hs/vs/de/ls/fs/err",
          W'({pixel_tick, h_sync, v_sync, de, line_start, frame_start, cfg_err}),
          W'({e_tick, e_hs, e_vs, e_de, e_ls, e_fs, err}));
      chk("h_pixel", h_pixel, W'(e_hp));
      chk("v_pixel", v_pixel, W'(e_vp));
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic wr(input int a, input int d);
      cfg_we   = 1'b1;
      cfg_addr = 4'(a);
      cfg_data = W'(d);
      step();
      cfg_we   = 1'b0;
   endtask

   initial begin
      int a, d;
      reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      run(2);
      reset = 1'b0;
      run(2000);
      wr(0, 320);
      run(11000);
      wr(2, 0);
      run(5000);
      wr(2, 96);
      run(5000);
      wr(9, 0);
      run(5000);
      wr(0, 12); wr(1, 2); wr(2, 3); wr(3, 2);
      wr(4, 5);  wr(5, 1); wr(6, 2); wr(7, 1);
      wr(8, 3);  wr(9, 7);
      run(1500);
      wr(9, 3'b011);
      wr(2, 0);
      run(800);
      wr(9, 0);
      run(500);
      for (int k = 0; k < 40; k++) begin
         run($urandom_range(50, 400));
         a = $urandom_range(0, 15);
         if (a < 8)       d = $urandom_range(0, 10);
         else if (a == 8) d = $urandom_range(0, 3);
         else             d = $urandom_range(0, 7);
         if (a == 9 && $urandom_range(0, 3) != 0) d = d | 1;
         wr(a, d);
      end
      wr(0, 5);
      wr(8, 2);
      run($urandom_range(3, 60));
      reset = 1'b1;
      run(1);
      reset = 1'b0;
      run(8500);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_programmable.md
Name: vga_timing_programmable

Overview:
Runtime-programmable VGA timing generator, successor to the fixed-parameter VGA timing block. Generates a pixel-rate tick, h/v sync, data-enable, pixel coordinates and line/frame strobes from a timing mode held in registers. Mode fields are written through a simple config port into staging registers and committed atomically at a frame boundary. Sits between the config bus and the pixel fetch/palette stage of the GPU.

Parameters:
CNT_W, 12, width of every timing field, counter and coordinate output
DEF_H_ACTIVE / DEF_H_FP / DEF_H_SYNC / DEF_H_BP, 640 / 16 / 96 / 48, reset horizontal timing
DEF_V_ACTIVE / DEF_V_FP / DEF_V_SYNC / DEF_V_BP, 480 / 10 / 2 / 33, reset vertical timing
DEF_DIV, 0, reset clock divider; pixel_tick every DEF_DIV+1 clk cycles
DEF_CTRL, 3'b001, reset control: bit0 enable, bit1 h_pol, bit2 v_pol (pol 0 = active-low pulse)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_we  in  1  write strobe, one write per asserted cycle
cfg_addr  in  4  0-7 = h_active,h_fp,h_sync,h_bp,v_active,v_fp,v_sync,v_bp; 8 = div; 9 = ctrl; 10-15 ignored
cfg_data  in  CNT_W  write data (ctrl uses bits [2:0])
pixel_tick  out  1  one-clk pulse at pixel rate
h_sync  out  1  horizontal sync at programmed polarity
v_sync  out  1  vertical sync at programmed polarity
de  out  1  high while h_pos < h_active and v_pos < v_active
h_pixel  out  CNT_W  h_pos while de, else 0
v_pixel  out  CNT_W  v_pos while de, else 0
line_start  out  1  pulse on the tick where h_pos becomes 0
frame_start  out  1  pulse on the tick where h_pos and v_pos both become 0
cfg_err  out  1  sticky: last commit rejected

Behaviour:
- Reset (sync, active-high, dominates everything): staging and active regs load DEF_*; divider, h_pos, v_pos = 0; pixel_tick, de, line_start, frame_start, cfg_err = 0; h_pixel, v_pixel = 0; syncs at inactive level of DEF_CTRL polarity.
- All outputs registered; outputs reflect counter state after the same tick, 1 clk latency from pixel_tick; strobes are 1 clk wide.
- Divider: counts 0..div, pixel_tick asserted when count == div; div = 0 gives tick every clk.
- h_total = h_active+h_fp+h_sync+h_bp, v_total likewise, computed in CNT_W+2 bits; counters sized CNT_W+2.
- On tick: h_pos == h_total-1 wraps to 0 and advances v_pos; v_pos == v_total-1 wraps to 0.
- Sync pulse active for h_active+h_fp <= h_pos < h_active+h_fp+h_sync (vertical analogous); output = pulse XOR ~pol.
- cfg writes only touch staging; active regs unchanged mid-frame.
- Commit: on the tick where the frame wraps (h and v at last position), or every clk while active enable = 0, staging is copied to active. Commit rejected if any of h_active, h_sync, v_active, v_sync = 0, or h_total / v_total overflow CNT_W+1 bits: active regs kept, cfg_err set; successful commit clears cfg_err.
- cfg write in the same cycle as commit: new value is included in that commit.
- Enable = 0: divider and counters held at 0, no ticks, de = 0, syncs inactive, strobes 0. Enable 0->1 commit: first tick after it produces frame_start with h=0, v=0.
- Changing div takes effect at commit only; divider count resets to 0 on commit of a new div.

Decomposition:
- Package vga_timing_pkg: cfg address constants, ctrl bit indices, default 640x480@60 mode constants, CNT_W.
- One sub-module: vga_tick_divider (programmable clock-enable counter, clk/reset/enable/div -> tick).

Test Plan:
- Defaults, div 0 -> line 800 ticks, h_sync low at h_pos 656..751 (96 ticks), v_sync low lines 490..491, frame 420000 ticks, de high 640x480 ticks/frame.
- Write h_active=320 at v_pos 100 -> current frame keeps 800-tick lines; from next frame_start line is 480 ticks, de 320 wide.
- div=3 with enable toggled -> pixel_tick every 4 clk, frame 1680000 clk, frame_start on first tick after enable.
- ctrl=3'b111 -> h_sync and v_sync high only during their pulses; low otherwise.
- Write h_sync=0 then frame wrap -> cfg_err=1, 640x480 timing continues unchanged; valid rewrite clears cfg_err next frame.
- Assert reset at h_pos 300, v_pos 200 -> next clk all outputs at reset values, staging back to defaults, counting restarts at 0,0.
